// File: rtl/mem_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : mem_lsu
//  Purpose  : MEM-stage load/store unit. Validates size/alignment, drives a
//             request/grant + rvalid data-memory bus, aligns store lanes,
//             extracts/extends load data, and stalls the pipeline while busy.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_lsu (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic [31:0] rdata,
   output logic        access_err,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_wstrb,
   input  logic        bus_gnt,
   input  logic        bus_rvalid,
   input  logic [31:0] bus_rdata
);

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [3:0] TMO_MAX = 4'd15;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_e;

   state_e      state_q, state_d;
   logic [3:0]  tmo_q, tmo_d;
   logic [1:0]  addr_lo_q, addr_lo_d;
   logic [2:0]  f3_q, f3_d;
   logic        bus_req_q, bus_req_d;
   logic        bus_we_q, bus_we_d;
   logic [31:0] bus_addr_q, bus_addr_d;
   logic [31:0] bus_wdata_q, bus_wdata_d;
   logic [3:0]  bus_wstrb_q, bus_wstrb_d;
   logic [31:0] rdata_q, rdata_d;
   logic        access_err_q, access_err_d;

   logic        req_any, req_one, f3_ok, aligned, legal;
   logic [3:0]  strb_new;
   logic [31:0] wdata_new;
   logic [31:0] rd_shift, rd_ext;

   // Decode the incoming control word: legality, alignment and store lane layout
   always_comb begin
      req_any = mem_read | mem_write;
      req_one = mem_read ^ mem_write;
      case (funct3)
         F3_B, F3_H, F3_W: f3_ok = 1'b1;
         F3_BU, F3_HU:     f3_ok = mem_read;   // no unsigned store forms
         default:          f3_ok = 1'b0;
      endcase
      case (funct3[1:0])
         2'b00:   aligned = 1'b1;
         2'b01:   aligned = ~addr[0];
         2'b10:   aligned = (addr[1:0] == 2'b00);
         default: aligned = 1'b0;
      endcase
      legal = req_one & f3_ok & aligned;
      case (funct3[1:0])
         2'b00: begin
            strb_new  = 4'b0001 << addr[1:0];
            wdata_new = {4{wdata[7:0]}};
         end
         2'b01: begin
            strb_new  = 4'b0011 << addr[1:0];
            wdata_new = {2{wdata[15:0]}};
         end
         default: begin
            strb_new  = 4'b1111;
            wdata_new = wdata;
         end
      endcase
      if (!mem_write) begin
         strb_new = 4'b0000;
      end
   end

   // Select the addressed byte/half of the returned word and extend it
   always_comb begin
      rd_shift = bus_rdata >> {addr_lo_q, 3'b000};
      case (f3_q)
         F3_B:    rd_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
         F3_H:    rd_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
         F3_BU:   rd_ext = {24'd0, rd_shift[7:0]};
         F3_HU:   rd_ext = {16'd0, rd_shift[15:0]};
         default: rd_ext = rd_shift;   // word: address low bits are zero
      endcase
   end

   // Next-state and next-output computation for the access sequencer
   always_comb begin
      state_d      = state_q;
      tmo_d        = tmo_q;
      addr_lo_d    = addr_lo_q;
      f3_d         = f3_q;
      bus_req_d    = bus_req_q;
      bus_we_d     = bus_we_q;
      bus_addr_d   = bus_addr_q;
      bus_wdata_d  = bus_wdata_q;
      bus_wstrb_d  = bus_wstrb_q;
      rdata_d      = rdata_q;
      access_err_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (legal) begin
               state_d     = S_REQ;
               tmo_d       = 4'd0;
               addr_lo_d   = addr[1:0];
               f3_d        = funct3;
               bus_req_d   = 1'b1;
               bus_we_d    = mem_write;
               bus_addr_d  = {addr[31:2], 2'b00};
               bus_wdata_d = wdata_new;
               bus_wstrb_d = strb_new;
            end else if (req_any) begin
               access_err_d = 1'b1;
            end
         end
         S_REQ: begin
            tmo_d = tmo_q + 4'd1;
            if (bus_gnt) begin
               bus_req_d = 1'b0;
               state_d   = bus_we_q ? S_DONE : S_WAIT;
            end else if (tmo_q == TMO_MAX) begin
               bus_req_d    = 1'b0;
               state_d      = S_DONE;
               access_err_d = 1'b1;
               rdata_d      = 32'd0;
            end
         end
         S_WAIT: begin
            tmo_d = tmo_q + 4'd1;
            if (bus_rvalid) begin
               rdata_d = rd_ext;
               state_d = S_DONE;
            end else if (tmo_q == TMO_MAX) begin
               state_d      = S_DONE;
               access_err_d = 1'b1;
               rdata_d      = 32'd0;
            end
         end
         default: begin
            // DONE: one unstalled cycle; new requests wait for IDLE
            state_d = S_IDLE;
         end
      endcase
   end

   // State and registered outputs, cleared immediately by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         tmo_q        <= 4'd0;
         addr_lo_q    <= 2'd0;
         f3_q         <= 3'd0;
         bus_req_q    <= 1'b0;
         bus_we_q     <= 1'b0;
         bus_addr_q   <= 32'd0;
         bus_wdata_q  <= 32'd0;
         bus_wstrb_q  <= 4'd0;
         rdata_q      <= 32'd0;
         access_err_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         tmo_q        <= tmo_d;
         addr_lo_q    <= addr_lo_d;
         f3_q         <= f3_d;
         bus_req_q    <= bus_req_d;
         bus_we_q     <= bus_we_d;
         bus_addr_q   <= bus_addr_d;
         bus_wdata_q  <= bus_wdata_d;
         bus_wstrb_q  <= bus_wstrb_d;
         rdata_q      <= rdata_d;
         access_err_q <= access_err_d;
      end
   end

   // Stall must rise in the accepting IDLE cycle, so it is combinational
   always_comb begin
      stall = rst_n & (((state_q == S_IDLE) & legal) |
                       (state_q == S_REQ) | (state_q == S_WAIT));
   end

   assign rdata      = rdata_q;
   assign access_err = access_err_q;
   assign bus_req    = bus_req_q;
   assign bus_we     = bus_we_q;
   assign bus_addr   = bus_addr_q;
   assign bus_wdata  = bus_wdata_q;
   assign bus_wstrb  = bus_wstrb_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_lsu
//  Purpose  : Scoreboard bench for mem_lsu: directed accesses push expected
//             bus requests and responses; monitors pop and compare.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_lsu;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        mem_read = 1'b0;
   logic        mem_write = 1'b0;
   logic [2:0]  funct3 = 3'd0;
   logic [31:0] addr = 32'd0;
   logic [31:0] wdata = 32'd0;
   logic        bus_gnt = 1'b0;
   logic        bus_rvalid = 1'b0;
   logic [31:0] bus_rdata = 32'd0;
   logic        stall;
   logic [31:0] rdata;
   logic        access_err;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_wstrb;

   mem_lsu dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .funct3     (funct3),
      .addr       (addr),
      .wdata      (wdata),
      .stall      (stall),
      .rdata      (rdata),
      .access_err (access_err),
      .bus_req    (bus_req),
      .bus_we     (bus_we),
      .bus_addr   (bus_addr),
      .bus_wdata  (bus_wdata),
      .bus_wstrb  (bus_wstrb),
      .bus_gnt    (bus_gnt),
      .bus_rvalid (bus_rvalid),
      .bus_rdata  (bus_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          stall_cycles;
   } resp_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  strb;
      logic [31:0] wdata;
   } bus_t;

   resp_t resp_q[$];
   bus_t  bus_q[$];
   resp_t r_exp;
   bus_t  b_exp;

   int compared = 0;
   int mismatched = 0;
   int run = 0;
   logic prev_req = 1'b0;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Response monitor: a DONE cycle (stall falling) or an error pulse is a response
   always @(negedge clk) begin
      if (!rst_n) begin
         run = 0;
      end else if (stall) begin
         run = run + 1;
      end else begin
         if (access_err || run > 0) begin
            if (resp_q.size() == 0) begin
               compared++;
               mismatched++;
               $display("FAIL resp_unexpected: got err=%0b rdata=0x%08h, expected no response", access_err, rdata);
            end else begin
               r_exp = resp_q.pop_front();
               check32("resp_err", 32'(access_err), 32'(r_exp.err));
               check32("resp_rdata", rdata, r_exp.rdata);
               check32("resp_stall_cycles", 32'(run), 32'(r_exp.stall_cycles));
            end
         end
         run = 0;
      end
   end

   // Bus monitor: each new request is checked against the next expected one
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_req = 1'b0;
      end else begin
         if (bus_req && !prev_req) begin
            if (bus_q.size() == 0) begin
               compared++;
               mismatched++;
               $display("FAIL bus_unexpected: got bus_req=1 addr=0x%08h, expected no request", bus_addr);
            end else begin
               b_exp = bus_q.pop_front();
               check32("bus_we", 32'(bus_we), 32'(b_exp.we));
               check32("bus_addr", bus_addr, b_exp.addr);
               check32("bus_wstrb", 32'(bus_wstrb), 32'(b_exp.strb));
               if (b_exp.we) check32("bus_wdata", bus_wdata, b_exp.wdata);
            end
         end
         prev_req = bus_req;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check32({tag, "_stall"}, 32'(stall), 32'd0);
      check32({tag, "_bus_req"}, 32'(bus_req), 32'd0);
      check32({tag, "_bus_we"}, 32'(bus_we), 32'd0);
      check32({tag, "_bus_wstrb"}, 32'(bus_wstrb), 32'd0);
      check32({tag, "_bus_addr"}, bus_addr, 32'd0);
      check32({tag, "_bus_wdata"}, bus_wdata, 32'd0);
      check32({tag, "_rdata"}, rdata, 32'd0);
      check32({tag, "_access_err"}, 32'(access_err), 32'd0);
   endtask

   // One access: drive the request, play the memory side, push expectations
   task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int gnt_dly, input int rv_dly, input logic [31:0] word,
                        input logic legal, input logic [3:0] ex_strb, input logic [31:0] ex_bwd,
                        input logic ex_err, input logic [31:0] ex_rdata, input int ex_stall,
                        input logic poke_done);
      resp_t r;
      bus_t  b;
      r.err = ex_err;
      r.rdata = ex_rdata;
      r.stall_cycles = ex_stall;
      resp_q.push_back(r);
      if (legal) begin
         b.we = wr;
         b.addr = {a[31:2], 2'b00};
         b.strb = ex_strb;
         b.wdata = ex_bwd;
         bus_q.push_back(b);
      end
      step();
      mem_read = rd;
      mem_write = wr;
      funct3 = f3;
      addr = a;
      wdata = wd;
      step();
      mem_read = 1'b0;
      mem_write = 1'b0;
      if (legal) begin
         bus_gnt = (gnt_dly == 0);
         for (int i = 1; i <= gnt_dly; i++) begin
            step();
            bus_gnt = (i == gnt_dly);
         end
         step();
         bus_gnt = 1'b0;
         if (rd) begin
            bus_rvalid = (rv_dly == 0);
            bus_rdata = (rv_dly == 0) ? word : 32'h5A5A5A5A;
            for (int i = 1; i <= rv_dly; i++) begin
               step();
               bus_rvalid = (i == rv_dly);
               bus_rdata = (i == rv_dly) ? word : 32'h5A5A5A5A;
            end
         end else begin
            // stray read data in a store's DONE cycle must not reach rdata
            bus_rvalid = 1'b1;
            bus_rdata = 32'hFFFFFFFF;
         end
         step();
         bus_rvalid = 1'b0;
         if (poke_done) begin
            mem_read = 1'b1;
            funct3 = 3'b010;
            addr = 32'h300;
         end
         step();
         mem_read = 1'b0;
      end
      repeat (2) step();
   endtask

   initial begin
      #1 rst_n = 1'b0;
      #2 check_reset_outputs("reset");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      step();

      //    rd  wr  f3      addr        wdata         gd rv word          legal strb     bus_wdata     err  rdata         stall poke
      issue(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0,        1, 4'b1111, 32'hDEADBEEF, 0, 32'h00000000, 2, 0);
      issue(1, 0, 3'b000, 32'h203, 32'h0,        0, 0, 32'h80FF1234, 1, 4'b0000, 32'h0,        0, 32'hFFFFFF80, 3, 1);
      issue(1, 0, 3'b100, 32'h203, 32'h0,        0, 0, 32'h80FF1234, 1, 4'b0000, 32'h0,        0, 32'h00000080, 3, 0);
      issue(0, 1, 3'b001, 32'h012, 32'h0000ABCD, 0, 0, 32'h0,        1, 4'b1100, 32'hABCDABCD, 0, 32'h00000080, 2, 0);
      issue(1, 0, 3'b001, 32'h202, 32'h0,        1, 2, 32'h80FF1234, 1, 4'b0000, 32'h0,        0, 32'hFFFF80FF, 6, 0);
      issue(1, 0, 3'b101, 32'h200, 32'h0,        0, 0, 32'h80FF1234, 1, 4'b0000, 32'h0,        0, 32'h00001234, 3, 0);
      issue(0, 1, 3'b000, 32'h101, 32'h000000A5, 3, 0, 32'h0,        1, 4'b0010, 32'hA5A5A5A5, 0, 32'h00001234, 5, 0);
      issue(1, 0, 3'b010, 32'h104, 32'h0,        0, 0, 32'hCAFEF00D, 1, 4'b0000, 32'h0,        0, 32'hCAFEF00D, 3, 0);
      // illegal accesses: misaligned word, misaligned half, both strobes, bad funct3
      issue(1, 0, 3'b010, 32'h102, 32'h0,        0, 0, 32'h0,        0, 4'b0000, 32'h0,        1, 32'hCAFEF00D, 0, 0);
      issue(0, 1, 3'b001, 32'h013, 32'h0,        0, 0, 32'h0,        0, 4'b0000, 32'h0,        1, 32'hCAFEF00D, 0, 0);
      issue(1, 1, 3'b010, 32'h100, 32'h0,        0, 0, 32'h0,        0, 4'b0000, 32'h0,        1, 32'hCAFEF00D, 0, 0);
      issue(1, 0, 3'b011, 32'h000, 32'h0,        0, 0, 32'h0,        0, 4'b0000, 32'h0,        1, 32'hCAFEF00D, 0, 0);
      issue(0, 1, 3'b100, 32'h000, 32'h0,        0, 0, 32'h0,        0, 4'b0000, 32'h0,        1, 32'hCAFEF00D, 0, 0);
      // grant withheld 20 cycles: timeout after 16 REQ cycles, late gnt/rvalid ignored
      issue(1, 0, 3'b010, 32'h108, 32'h0,        20, 0, 32'h77777777, 1, 4'b0000, 32'h0,      1, 32'h00000000, 17, 0);
      issue(1, 0, 3'b010, 32'h108, 32'h0,        0, 0, 32'h12345678, 1, 4'b0000, 32'h0,        0, 32'h12345678, 3, 0);

      // reset while waiting for read data
      b_exp.we = 1'b0;
      b_exp.addr = 32'h10C;
      b_exp.strb = 4'b0000;
      b_exp.wdata = 32'h0;
      bus_q.push_back(b_exp);
      step();
      mem_read = 1'b1;
      funct3 = 3'b010;
      addr = 32'h10C;
      step();
      mem_read = 1'b0;
      bus_gnt = 1'b1;
      step();
      bus_gnt = 1'b0;
      check32("wait_stall", 32'(stall), 32'd1);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("midreset");
      repeat (2) step();
      rst_n = 1'b1;
      step();
      issue(0, 1, 3'b010, 32'h020, 32'h11223344, 0, 0, 32'h0,        1, 4'b1111, 32'h11223344, 0, 32'h00000000, 2, 0);

      repeat (3) step();
      check32("resp_queue_left", 32'(resp_q.size()), 32'd0);
      check32("bus_queue_left", 32'(bus_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire
